// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter for a single-port memory with starvation guard
module mem_arbiter #(
    parameter int WIDTH  = 64,
    parameter int STARVE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_ack,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] waitcnt;
    logic       starve;
    logic       grant_i;
    logic       grant_d;
    logic       complete;

    // Once data has won STARVE times in a row over a waiting fetch, the fetch wins.
    assign starve = i_req && (waitcnt >= STARVE_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !starve) begin
                    state_nxt = DGNT;
                    grant_d   = 1'b1;
                end else if (i_req) begin
                    state_nxt = IGNT;
                    grant_i   = 1'b1;
                end
            end
            IGNT, DGNT: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                    complete  = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitcnt <= 4'd0;
        end else if (grant_i) begin
            waitcnt <= 4'd0;
        end else if (grant_d && i_req && (waitcnt != 4'hF)) begin
            waitcnt <= waitcnt + 4'd1;
        end
    end

    // Memory-side request: address/we/wdata latched at grant and held until completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (complete) begin
            mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= complete && (state == IGNT);
            d_ack <= complete && (state == DGNT);
            if (complete && (state == IGNT)) begin
                i_rdata <= mem_rdata;
            end
            // Writes leave the last read value visible on d_rdata.
            if (complete && (state == DGNT) && !mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_req = 1'b0;
    logic [W-1:0] i_addr = '0;
    logic         i_ack;
    logic [W-1:0] i_rdata;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [W-1:0] d_addr = '0;
    logic [W-1:0] d_wdata = '0;
    logic         d_ack;
    logic [W-1:0] d_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    mem_arbiter #(.WIDTH(W), .STARVE(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        logic [W-1:0] addr;
        bit           we;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           ack_delay = 1;
    bit           resp_en = 1'b1;
    logic [W-1:0] m_d_rdata = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        if (a == 64'h40) return 64'h8B02_0020;
        return a ^ 64'h5A5A_0000;
    endfunction

    // Memory model: acks ack_delay cycles after it first sees mem_req.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (resp_en && mem_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: checks the in-flight grant every cycle and pops on each ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("one_hot_ack", W'(i_ack & d_ack), '0);
                if (mem_req) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_mem_req", W'(mem_req), '0);
                    end else begin
                        chk("mem_addr", mem_addr, exp_q[0].addr);
                        chk("mem_we", W'(mem_we), W'(exp_q[0].we));
                        if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    end
                end
                if (i_ack || d_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", W'({i_ack, d_ack}), '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_port_is_d", W'(d_ack), W'(e.is_d));
                        if (e.is_d) chk("d_rdata", d_rdata, e.rdata);
                        else        chk("i_rdata", i_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic push_i(input logic [W-1:0] a, input logic [W-1:0] rd);
        exp_q.push_back('{1'b0, a, 1'b0, '0, rd});
    endtask

    task automatic push_d(input logic [W-1:0] a, input bit we, input logic [W-1:0] wd,
                          input logic [W-1:0] rd);
        if (we) exp_q.push_back('{1'b1, a, 1'b1, wd, m_d_rdata});
        else begin
            exp_q.push_back('{1'b1, a, 1'b0, wd, rd});
            m_d_rdata = rd;
        end
    endtask

    task automatic i_txn(input logic [W-1:0] a);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        i_addr = a;
        i_req  = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (i_ack) begin
                got = 1'b1;
                break;
            end
        end
        i_req = 1'b0;
        chk("i_txn_done", W'(got), W'(1));
    endtask

    task automatic d_txn(input logic [W-1:0] a, input bit we, input logic [W-1:0] wd);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        d_addr  = a;
        d_we    = we;
        d_wdata = wd;
        d_req   = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (d_ack) begin
                got = 1'b1;
                break;
            end
        end
        d_req = 1'b0;
        chk("d_txn_done", W'(got), W'(1));
    endtask

    initial begin
        #3;
        chk("rst_mem_req", W'(mem_req), '0);
        chk("rst_mem_we", W'(mem_we), '0);
        chk("rst_i_ack", W'(i_ack), '0);
        chk("rst_d_ack", W'(d_ack), '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Instruction-only read
        push_i(64'h40, 64'h8B02_0020);
        i_txn(64'h40);
        chk("i_rdata_hold", i_rdata, 64'h8B02_0020);

        // Simultaneous: data write first, then instruction
        push_d(64'h100, 1'b1, 64'hDEAD, '0);
        push_i(64'h44, 64'h5A5A_0044);
        fork
            i_txn(64'h44);
            d_txn(64'h100, 1'b1, 64'hDEAD);
        join
        chk("d_rdata_after_write", d_rdata, '0);

        // Slow memory
        ack_delay = 5;
        push_i(64'h48, 64'h5A5A_0048);
        i_txn(64'h48);
        push_d(64'h300, 1'b0, '0, 64'h5A5A_0300);
        d_txn(64'h300, 1'b0, '0);
        ack_delay = 1;

        // Starvation: four data grants, then the fetch, then the last data
        push_d(64'h200, 1'b0, '0, 64'h5A5A_0200);
        push_d(64'h208, 1'b0, '0, 64'h5A5A_0208);
        push_d(64'h210, 1'b0, '0, 64'h5A5A_0210);
        push_d(64'h218, 1'b0, '0, 64'h5A5A_0218);
        push_i(64'h80, 64'h5A5A_0080);
        push_d(64'h220, 1'b0, '0, 64'h5A5A_0220);
        fork
            i_txn(64'h80);
            begin
                for (int k = 0; k < 5; k++) d_txn(64'h200 + 64'(8 * k), 1'b0, '0);
            end
        join

        // Wait counter cleared: data wins again
        push_d(64'h108, 1'b1, 64'hBEEF, '0);
        push_i(64'h4C, 64'h5A5A_004C);
        fork
            i_txn(64'h4C);
            d_txn(64'h108, 1'b1, 64'hBEEF);
        join

        // Stray ack in IDLE
        repeat (2) @(posedge clk);
        #2;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_i_ack", W'(i_ack), '0);
        chk("stray_d_ack", W'(d_ack), '0);
        chk("stray_mem_req", W'(mem_req), '0);
        chk("stray_i_rdata", i_rdata, 64'h5A5A_004C);
        chk("stray_d_rdata", d_rdata, 64'h5A5A_0220);

        // Reset two cycles into a data grant
        resp_en = 1'b0;
        exp_q.push_back('{1'b1, 64'h400, 1'b0, '0, '0});
        @(posedge clk);
        #1;
        d_addr = 64'h400;
        d_we   = 1'b0;
        d_req  = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_mem_req", W'(mem_req), '0);
        chk("arst_mem_addr", mem_addr, '0);
        chk("arst_d_rdata", d_rdata, '0);
        chk("arst_i_rdata", i_rdata, '0);
        exp_q.delete();
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ack_d_ack", W'(d_ack), '0);
            chk("late_ack_mem_req", W'(mem_req), '0);
        end
        resp_en = 1'b1;

        // Normal operation after reset
        push_i(64'h40, 64'h8B02_0020);
        i_txn(64'h40);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        chk("queue_drained", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: memarbiter

Interface
REQ-001 Parameter WIDTH, default 64, data and address width in bits.
REQ-002 Parameter STARVE, default 4, consecutive data grants tolerated while an instruction request waits; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 i_req  input  1  instruction-fetch request; held high until i_ack is sampled.
REQ-006 i_addr  input  WIDTH  instruction address.
REQ-007 i_ack  output  1  one-cycle instruction completion pulse.
REQ-008 i_rdata  output  WIDTH  fetched instruction word, registered.
REQ-009 d_req  input  1  data request; held high until d_ack is sampled.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  WIDTH  data address.
REQ-012 d_wdata  input  WIDTH  write data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  WIDTH  read data, registered.
REQ-015 mem_req  output  1  request to the single-port memory, registered.
REQ-016 mem_we  output  1  write enable to memory, registered.
REQ-017 mem_addr  output  WIDTH  latched address to memory.
REQ-018 mem_wdata  output  WIDTH  latched write data to memory.
REQ-019 mem_rdata  input  WIDTH  memory read data; valid when mem_ack = 1.
REQ-020 mem_ack  input  1  memory completion; may arrive 1 or more cycles after mem_req rises.

Function
REQ-021 FSM states: IDLE, IGNT, DGNT, DONE.
REQ-022 IDLE: at the edge, if d_req=1 and starvation is not reached, go to DGNT; else if i_req=1, go to IGNT; else stay in IDLE.
REQ-023 Starvation is reached when waitcnt >= STARVE and i_req=1; in that case IGNT is taken even if d_req=1.
REQ-024 waitcnt (4 bits) increments, saturating at 15, on each IDLE->DGNT edge where i_req=1; it clears to 0 on each IDLE->IGNT edge.
REQ-025 On entry to IGNT/DGNT, mem_req=1, and the requester's address, we (0 for instruction) and wdata are latched into mem_addr/mem_we/mem_wdata; these hold stable until completion.
REQ-026 In IGNT/DGNT, an edge with mem_ack=1 does all of the following: mem_req goes to 0; the granted port's ack goes to 1 for exactly one cycle; the state moves to DONE.
REQ-027 On that edge, i_rdata captures mem_rdata for IGNT; d_rdata captures mem_rdata for a DGNT read only; a DGNT write leaves d_rdata unchanged.
REQ-028 DONE lasts exactly one cycle, then the state goes to IDLE; no arbitration happens in DONE, so a requester's still-high req is not re-granted.
REQ-029 mem_ack while in IDLE or DONE is ignored, and no ack is issued.
REQ-030 Minimum latency: req sampled at edge N, mem_req high after N, mem_ack sampled at N+1, ack high after N+1, next grant possible at edge N+3.
REQ-031 At most one of i_ack/d_ack is high in any cycle, and mem_req is never high in DONE or IDLE.
REQ-032 Request inputs that change while not granted have no effect until the next IDLE sampling.

Reset
REQ-033 rst=0 asynchronously forces the following, independent of clk: state=IDLE, waitcnt=0, mem_req=0, mem_we=0, i_ack=0, d_ack=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0.
REQ-034 Reset during IGNT/DGNT abandons the transaction: no ack is issued, and a late mem_ack after rst returns to 1 is ignored per REQ-029.
REQ-035 The first arbitration occurs at the first rising edge after rst deasserts.

Verification
REQ-036 Instruction-only read: i_req=1, i_addr=0x40, mem_ack one cycle later with mem_rdata=0x8B020020 -> mem_addr=0x40, mem_we=0, i_ack single pulse, i_rdata=0x8B020020, d_ack never high.
REQ-037 Simultaneous requests: i_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD -> DGNT first, mem_we=1, mem_wdata=0xDEAD, d_ack pulses, d_rdata unchanged, then DONE, then IGNT with i_ack after the next mem_ack.
REQ-038 Starvation with STARVE=4: d_req held high continuously (re-asserted after each ack) while i_req=1 -> exactly 4 data grants, then 1 instruction grant, then waitcnt=0.
REQ-039 Slow memory: mem_ack delayed 5 cycles -> mem_req and mem_addr stay stable for all 5 cycles, and exactly one ack is issued.
REQ-040 Reset mid-transaction: rst=0 two cycles into DGNT -> mem_req=0 immediately without waiting for a clock edge; mem_ack=1 after release -> no d_ack, state stays IDLE.
REQ-041 Stray ack: mem_ack=1 in IDLE with no requests -> no ack is issued and all outputs are unchanged.
